booth_seq_mul: RTL and testbench



---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step.sv | 31 +++
 rtl/booth_seq_mul.sv | 115 +++++++++++
 tb/tb_booth_seq_mul.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// The iteration count covers the extra sign/zero-extension bit of each operand.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int booth_iters(input int width);
        return width + 1;
    endfunction

    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into A, then arithmetic
// right shift of the concatenation {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    input  logic         q_1,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_o,
    output logic [W-1:0] q_o,
    output logic         q_1_o
);

    logic [W-1:0] sum;

    always_comb begin
        sum = a;
        unique case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_o   = {sum[W-1], sum[W-1:1]};
        q_o   = {sum[0], q[W-1:1]};
        q_1_o = q[0];
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one step per clock.
// Operands are widened by one bit so both modes share the same signed datapath.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = booth_cnt_w(WIDTH);
    localparam logic [CW-1:0] ITERS = CW'(booth_iters(WIDTH));

    state_e            state_q, state_d;
    logic [W1-1:0]     a_q, a_d;
    logic [W1-1:0]     q_q, q_d;
    logic              q1_q, q1_d;
    logic [W1-1:0]     m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [W1-1:0]     a_n;
    logic [W1-1:0]     q_n;
    logic              q1_n;
    logic [W1-1:0]     x_ext;
    logic [W1-1:0]     y_ext;

    assign x_ext = {signed_mode & X[WIDTH-1], X};
    assign y_ext = {signed_mode & Y[WIDTH-1], Y};

    booth_step #(
        .W(W1)
    ) u_step (
        .a     (a_q),
        .q     (q_q),
        .q_1   (q1_q),
        .m     (m_q),
        .a_o   (a_n),
        .q_o   (q_n),
        .q_1_o (q1_n)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = y_ext;
                    q1_d    = 1'b0;
                    m_d     = x_ext;
                    cnt_d   = ITERS;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_n;
                q_d   = q_n;
                q1_d  = q1_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Low 2*WIDTH bits of the widened product are exact.
                    z_d     = {a_n[WIDTH-2:0], q_n};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Scoreboard bench: WIDTH=4 instance (exhaustive + random) and WIDTH=16 instance.
// Expected products come from plain integer multiplication of the operands.
module tb_booth_seq_mul;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic        signed_mode;
    logic [3:0]  X;
    logic [3:0]  Y;
    logic        busy;
    logic        done;
    logic [7:0]  Z;

    logic        b_start;
    logic        b_signed_mode;
    logic [15:0] b_X;
    logic [15:0] b_Y;
    logic        b_busy;
    logic        b_done;
    logic [31:0] b_Z;

    typedef struct {
        logic [7:0] z;
        int         acc;
    } e4_t;

    typedef struct {
        logic [31:0] z;
        int          acc;
    } e16_t;

    e4_t  exp4[$];
    e16_t exp16[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int issued4 = 0;
    int ndone4 = 0;
    int issued16 = 0;
    int ndone16 = 0;

    logic [7:0] last_z;
    logic       done_prev;

    booth_seq_mul #(
        .WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .Z           (Z)
    );

    booth_seq_mul #(
        .WIDTH(16)
    ) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (b_start),
        .signed_mode (b_signed_mode),
        .X           (b_X),
        .Y           (b_Y),
        .busy        (b_busy),
        .done        (b_done),
        .Z           (b_Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint refmul(input bit sm, input int w,
                                      input longint x, input longint y);
        longint a;
        longint b;
        a = x;
        b = y;
        if (sm && x >= (longint'(1) << (w - 1))) a = x - (longint'(1) << w);
        if (sm && y >= (longint'(1) << (w - 1))) b = y - (longint'(1) << w);
        return a * b;
    endfunction

    // WIDTH=4 monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_z    = 8'h00;
            done_prev = 1'b0;
        end else begin
            if (done) begin
                ndone4++;
                checks++;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done4_pulse done high two cycles in a row");
                end
                checks++;
                if (exp4.size() == 0) begin
                    errors++;
                    $display("FAIL done4_unexpected Z=%h with no pending op", Z);
                end else begin
                    e4_t e;
                    e = exp4.pop_front();
                    checks++;
                    if (Z !== e.z) begin
                        errors++;
                        $display("FAIL z4 got %h required %h", Z, e.z);
                    end
                    checks++;
                    if (cyc - e.acc != 5) begin
                        errors++;
                        $display("FAIL lat4 got %0d required 5", cyc - e.acc);
                    end
                end
                last_z = Z;
            end else begin
                checks++;
                if (Z !== last_z) begin
                    errors++;
                    $display("FAIL hold4 got %h required %h", Z, last_z);
                end
            end
            done_prev = done;
        end
    end

    // WIDTH=16 monitor
    always @(negedge clk) begin
        if (rst_n && b_done) begin
            ndone16++;
            checks++;
            if (exp16.size() == 0) begin
                errors++;
                $display("FAIL done16_unexpected Z=%h", b_Z);
            end else begin
                e16_t e;
                e = exp16.pop_front();
                checks++;
                if (b_Z !== e.z) begin
                    errors++;
                    $display("FAIL z16 got %h required %h", b_Z, e.z);
                end
                checks++;
                if (cyc - e.acc != 17) begin
                    errors++;
                    $display("FAIL lat16 got %0d required 17", cyc - e.acc);
                end
            end
        end
    end

    task automatic issue4(input bit sm, input logic [3:0] x, input logic [3:0] y);
        int n;
        e4_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue4_timeout busy=%0b required 0", busy);
            return;
        end
        signed_mode = sm;
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.z = 8'(refmul(sm, 4, longint'(x), longint'(y)));
        e.acc = cyc;
        exp4.push_back(e);
        issued4++;
        start = 1'b0;
        X = 4'($urandom);
        Y = 4'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic issue16(input bit sm, input logic [15:0] x, input logic [15:0] y);
        int n;
        e16_t e;
        n = 0;
        @(negedge clk);
        while (b_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (b_busy) begin
            checks++;
            errors++;
            $display("FAIL issue16_timeout busy=%0b required 0", b_busy);
            return;
        end
        b_signed_mode = sm;
        b_X = x;
        b_Y = y;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        e.z = 32'(refmul(sm, 16, longint'(x), longint'(y)));
        e.acc = cyc;
        exp16.push_back(e);
        issued16++;
        b_start = 1'b0;
        b_X = 16'($urandom);
        b_Y = 16'($urandom);
    endtask

    initial begin
        int n;
        logic [7:0] ix;
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        X = '0;
        Y = '0;
        b_start = 1'b0;
        b_signed_mode = 1'b0;
        b_X = '0;
        b_Y = '0;

        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Z !== 8'h00) begin
            errors++;
            $display("FAIL reset4 busy=%b done=%b Z=%h required 0 0 00", busy, done, Z);
        end
        checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || b_Z !== 32'h0) begin
            errors++;
            $display("FAIL reset16 busy=%b done=%b Z=%h required 0", b_busy, b_done, b_Z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue4(1'b1, 4'b1000, 4'b1000);
        issue4(1'b1, 4'd7, 4'hF);
        issue4(1'b0, 4'd7, 4'hF);

        // Start pulsed during RUN must be ignored.
        issue4(1'b0, 4'd3, 4'd5);
        @(negedge clk);
        @(negedge clk);
        X = 4'hF;
        Y = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Async reset during iteration 2 discards the op.
        issue4(1'b0, 4'd9, 4'd9);
        exp4.delete();
        issued4--;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Z !== 8'h00) begin
            errors++;
            $display("FAIL midreset busy=%b done=%b Z=%h required 0 0 00", busy, done, Z);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue4(1'b0, 4'd2, 4'd3);

        for (int sm = 0; sm < 2; sm++) begin
            for (int i = 0; i < 256; i++) begin
                ix = 8'(i);
                issue4(sm[0], ix[7:4], ix[3:0]);
            end
        end

        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            issue4(1'($urandom), 4'($urandom), 4'($urandom));
        end

        issue16(1'b1, 16'h8000, 16'h7FFF);
        issue16(1'b0, 16'hFFFF, 16'hFFFF);
        issue16(1'b1, 16'h8000, 16'h8000);
        for (int k = 0; k < 20; k++) begin
            issue16(1'($urandom), 16'($urandom), 16'($urandom));
        end

        n = 0;
        while ((exp4.size() != 0 || exp16.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp4.size() != 0 || exp16.size() != 0) begin
            errors++;
            $display("FAIL drain pending4=%0d pending16=%0d required 0", exp4.size(), exp16.size());
        end
        checks++;
        if (ndone4 != issued4) begin
            errors++;
            $display("FAIL count4 dones=%0d required %0d", ndone4, issued4);
        end
        checks++;
        if (ndone16 != issued16) begin
            errors++;
            $display("FAIL count16 dones=%0d required %0d", ndone16, issued16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
